// File: rtl/floating_addition_pkg.sv
// Shared binary32 constants and the packed field view used by the adder.
package floating_addition_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned BIAS   = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fadd_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fadd_lzc (
  input  logic [26:0] value_i,
  output logic [4:0]  count_o
);

  // Highest set bit wins because the scan runs upward and the last hit sticks.
  always_comb begin
    count_o = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value_i[i]) count_o = 5'(26 - i);
    end
  end

endmodule

// File: rtl/floating_addition.sv
// Binary32 adder, round-to-nearest-even, flush-to-zero, one registered stage.
// Defining FADD_IN_REG_EN adds an operand register in front (latency 2).
module floating_addition
  import floating_addition_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result
);

  logic [31:0] op_a, op_b;

`ifdef FADD_IN_REG_EN
  logic [31:0] a_q, b_q;

  // Optional operand capture stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= A;
      b_q <= B;
    end
  end

  assign op_a = a_q;
  assign op_b = b_q;
`else
  assign op_a = A;
  assign op_b = B;
`endif

  fp32_t fa, fb;
  assign fa = op_a;
  assign fb = op_b;

  logic              a_nan, b_nan, a_inf, b_inf, a_big, eff_sub;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              sign_l, sign_s;
  logic [EXP_W-1:0]  exp_l, exp_s, exp_diff;
  logic [23:0]       m_l, m_s;
  logic [26:0]       big, ext_s, lost_mask, aligned;
  logic [4:0]        shamt;

  // Classify, flush subnormals, order by magnitude and align the smaller operand.
  always_comb begin
    a_nan  = (fa.exp == EXP_MAX) && (fa.frac != '0);
    b_nan  = (fb.exp == EXP_MAX) && (fb.frac != '0);
    a_inf  = (fa.exp == EXP_MAX) && (fa.frac == '0);
    b_inf  = (fb.exp == EXP_MAX) && (fb.frac == '0);
    frac_a = (fa.exp == '0) ? '0 : fa.frac;
    frac_b = (fb.exp == '0) ? '0 : fb.frac;
    a_big  = {fa.exp, frac_a} >= {fb.exp, frac_b};
    sign_l = a_big ? fa.sign : fb.sign;
    sign_s = a_big ? fb.sign : fa.sign;
    exp_l  = a_big ? fa.exp : fb.exp;
    exp_s  = a_big ? fb.exp : fa.exp;
    m_l    = a_big ? {fa.exp != '0, frac_a} : {fb.exp != '0, frac_b};
    m_s    = a_big ? {fb.exp != '0, frac_b} : {fa.exp != '0, frac_a};
    eff_sub  = sign_l ^ sign_s;
    exp_diff = exp_l - exp_s;
    big      = {m_l, 3'b000};
    ext_s    = {m_s, 3'b000};
    shamt     = exp_diff[4:0];
    lost_mask = (27'd1 << shamt) - 27'd1;
    if (exp_diff >= 8'd26) begin
      aligned = {26'd0, |m_s};
    end else begin
      aligned = (ext_s >> shamt) | {26'd0, |(ext_s & lost_mask)};
    end
  end

  logic [27:0] sum_add;
  logic [26:0] sum_sub;
  logic [4:0]  lz;

  assign sum_add = {1'b0, big} + {1'b0, aligned};
  assign sum_sub = big - aligned;

  fadd_lzc u_lzc (
    .value_i (sum_sub),
    .count_o (lz)
  );

  logic              res_zero, zero_sign, round_up;
  logic [26:0]       norm;
  logic signed [9:0] exp_n, exp_f;
  logic [24:0]       mant_r;
  logic [22:0]       frac_f;

  // Normalize the raw sum/difference, then round to nearest-even.
  always_comb begin
    res_zero  = eff_sub ? (sum_sub == '0) : (sum_add == '0);
    zero_sign = eff_sub ? 1'b0 : sign_l;
    if (!eff_sub) begin
      if (sum_add[27]) begin
        norm  = {sum_add[27:2], sum_add[1] | sum_add[0]};
        exp_n = $signed({2'b00, exp_l}) + 10'sd1;
      end else begin
        norm  = sum_add[26:0];
        exp_n = $signed({2'b00, exp_l});
      end
    end else begin
      // Bit 0 is replicated so a sticky bit survives a one-place shift.
      norm  = (sum_sub << lz) | {26'd0, sum_sub[0]};
      exp_n = $signed({2'b00, exp_l}) - $signed({5'd0, lz});
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant_r[24]) begin
      frac_f = mant_r[23:1];
      exp_f  = exp_n + 10'sd1;
    end else begin
      frac_f = mant_r[22:0];
      exp_f  = exp_n;
    end
  end

  logic [31:0] res_d, result_q;

  // Specials take priority over the arithmetic path.
  always_comb begin
    res_d = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign))) begin
      res_d = QNAN;
    end else if (a_inf || b_inf) begin
      res_d = a_inf ? op_a : op_b;
    end else if (res_zero) begin
      res_d = {zero_sign, 31'd0};
    end else if (exp_f <= 10'sd0) begin
      res_d = {sign_l, 31'd0};
    end else if (exp_f >= $signed({2'b00, EXP_MAX})) begin
      res_d = {sign_l, EXP_MAX, 23'd0};
    end else begin
      res_d = {sign_l, exp_f[7:0], frac_f};
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) result_q <= '0;
    else     result_q <= res_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_floating_addition.sv
// Self-checking bench for floating_addition: directed cases, reset behaviour and
// randomized back-to-back pairs checked against a real-arithmetic reference.
module tb_floating_addition;

`ifdef FADD_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] A, B, result;

  floating_addition dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] expv;
    string       tag;
    int          due;
  } pend_t;

  pend_t pq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: result=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Binary32 to real, subnormals read as signed zero.
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'({3'b000, x[30:23]}) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Reference: exact-enough sum in double, then one RNE rounding to binary32.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s, up;
    real         r;
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] keep;
    logic [28:0] rem;
    int          e;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return 32'h7FC00000;
    if (a_inf) return a;
    if (b_inf) return b;
    r = to_real(a) + to_real(b);
    if (r == 0.0) begin
      if (a_zero && b_zero && a[31] && b[31]) return 32'h80000000;
      return 32'h00000000;
    end
    d    = $realtobits(r);
    s    = d[63];
    e    = int'(d[62:52]) - 896;
    m    = {1'b1, d[51:0]};
    keep = {1'b0, m[52:29]};
    rem  = m[28:0];
    up   = (rem > 29'h10000000) || ((rem == 29'h10000000) && keep[0]);
    keep = keep + {24'd0, up};
    if (keep[24]) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(e), keep[22:0]};
  endfunction

  task automatic tick();
    pend_t p;
    @(posedge clk);
    #1;
    cyc++;
    while (pq.size() > 0 && pq[0].due == cyc) begin
      p = pq.pop_front();
      check(p.tag, result, p.expv);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                      input string tag);
    pend_t p;
    A      = a;
    B      = b;
    p.expv = expv;
    p.tag  = tag;
    p.due  = cyc + LAT;
    pq.push_back(p);
    tick();
  endtask

  task automatic drain();
    A = '0;
    B = '0;
    for (int i = 0; i < LAT; i++) tick();
  endtask

  initial begin
    logic [31:0] a, b;
    int          mode;

    // Reset held: output stays zero, even with live operands.
    rst = 1'b1;
    A   = '0;
    B   = '0;
    #1;
    check("reset_async", result, 32'h0);
    @(posedge clk);
    #1;
    check("reset_hold", result, 32'h0);
    A = 32'h3F800000;
    B = 32'h40000000;
    @(posedge clk);
    #1;
    check("reset_blocks_output", result, 32'h0);
    A   = '0;
    B   = '0;
    rst = 1'b0;

    // Directed pairs, back to back.
    push(32'h3F800000, 32'h40000000, 32'h40400000, "one_plus_two");
    push(32'hBFC00000, 32'h40400000, 32'h3FC00000, "neg1p5_plus_3");
    push(32'h00000000, 32'h00000000, 32'h00000000, "zero_plus_zero");
    push(32'hC0200000, 32'h40200000, 32'h00000000, "exact_cancel");
    push(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf_minus_inf");
    push(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow_inf");
    push(32'h3F800000, 32'h33800000, 32'h3F800000, "tie_to_even");
    push(32'h3F800001, 32'h33800000, 32'h3F800002, "tie_round_up_odd");
    push(32'h80000000, 32'h80000000, 32'h80000000, "negz_plus_negz");
    push(32'h00000000, 32'h80000000, 32'h00000000, "posz_plus_negz");
    push(32'h00400000, 32'h3F800000, 32'h3F800000, "subnormal_flush");
    push(32'h80400000, 32'h00000000, 32'h00000000, "subnormal_plus_zero");
    push(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in");
    push(32'hFF800000, 32'h42000000, 32'hFF800000, "neginf_plus_finite");
    push(32'h7F800000, 32'h7F800000, 32'h7F800000, "inf_plus_inf");
    push(32'h3F800000, 32'hBF7FFFFF, 32'h33800000, "near_cancel");
    push(32'h4B800000, 32'h3F800000, 32'h4B800000, "align_diff24");
    push(32'h00800000, 32'h80000001, 32'h00800000, "min_normal_plus_sub");
    drain();

    // Randomized back-to-back pairs against the reference model.
    for (int i = 0; i < 300; i++) begin
      a    = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0: b = $urandom;
        1: begin
          a = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
          b = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
        end
        2: b = {~a[31], a[30:0] ^ 31'($urandom_range(0, 255))};
        default: b = {1'($urandom), 8'(a[30:23] - 8'($urandom_range(0, 30))), 23'($urandom)};
      endcase
      push(a, b, ref_add(a, b), $sformatf("rand%0d_%08h_%08h", i, a, b));
    end
    drain();

    // Reset asserted mid-stream: clears at once and discards in-flight work.
    push(32'h3F800000, 32'h40000000, 32'h40400000, "pre_reset_a");
    push(32'hBFC00000, 32'h40400000, 32'h3FC00000, "pre_reset_b");
    #2;
    rst = 1'b1;
    #1;
    check("reset_async_mid", result, 32'h0);
    pq.delete();
    A = '0;
    B = '0;
    @(posedge clk);
    #1;
    check("reset_mid_hold", result, 32'h0);
    rst = 1'b0;
    tick();
    check("inflight_discarded", result, 32'h0);
    push(32'h40000000, 32'h40000000, 32'h40800000, "post_reset_two_plus_two");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
